// File: rtl/mac_tx_arbiter.sv
// Round-robin transmit arbiter in front of mac_send: two clients, one MAC, IFG enforced between frames.
// Optional start watchdog in WAIT_START is compiled in with `define MAC_TX_ARB_TIMEOUT_EN.
module mac_tx_arbiter #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [10:0] len0,
  input  logic [10:0] len1,
  input  logic [47:0] dmac0,
  input  logic [47:0] dmac1,
  input  logic [15:0] type0,
  input  logic [15:0] type1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        fifo_rdreq0,
  output logic        fifo_rdreq1,
  input  logic [7:0]  fifo_rddata0,
  input  logic [7:0]  fifo_rddata1,
  output logic        tx_go,
  output logic [10:0] pyd_length,
  output logic [47:0] des_mac,
  output logic [15:0] type_length,
  input  logic        fifo_rdreq,
  output logic [7:0]  fifo_rddata,
  input  logic        gmii_tx_en
);

  localparam int CNT_MAX = (IFG_CYCLES > TIMEOUT_CYCLES) ? IFG_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_GO, S_WAIT, S_SEND, S_IFG} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [10:0]   len_q, len_d;
  logic [47:0]   dmac_q, dmac_d;
  logic [15:0]   type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    done_q, done_d;
  logic          sel;
  logic          active;

  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    if (l < 11'd46)        return 11'd46;
    else if (l > 11'd1500) return 11'd1500;
    else                   return l;
  endfunction

  // Contention goes to the requester not granted last; a lone request wins outright.
  assign sel = (req0 & req1) ? ~last_q : req1;

`ifdef MAC_TX_ARB_TIMEOUT_EN
  logic [1:0] err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    len_d   = len_q;
    dmac_d  = dmac_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    done_d  = 2'b00;
`ifdef MAC_TX_ARB_TIMEOUT_EN
    err_d   = 2'b00;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          owner_d = sel;
          len_d   = sel ? clamp_len(len1) : clamp_len(len0);
          dmac_d  = sel ? dmac1 : dmac0;
          type_d  = sel ? type1 : type0;
          state_d = S_GO;
        end
      end
      S_GO: begin
        last_d  = owner_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gmii_tx_en) begin
          state_d = S_SEND;
        end
`ifdef MAC_TX_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d[owner_q] = 1'b1;
          cnt_d          = '0;
          state_d        = S_IFG;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_SEND: begin
        if (!gmii_tx_en) begin
          done_d[owner_q] = 1'b1;
          cnt_d           = '0;
          state_d         = S_IFG;
        end
      end
      S_IFG: begin
        if (cnt_q == CW'(IFG_CYCLES - 1)) state_d = S_IDLE;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // "last granted = 1" makes requester 0 win the first contention
      len_q   <= '0;
      dmac_q  <= '0;
      type_q  <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      len_q   <= len_d;
      dmac_q  <= dmac_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef MAC_TX_ARB_TIMEOUT_EN
  always_ff @(posedge gmii_clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end
  assign err0 = err_q[0];
  assign err1 = err_q[1];
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  assign active      = (state_q == S_WAIT) || (state_q == S_SEND);
  assign tx_go       = (state_q == S_GO);
  assign gnt0        = tx_go & ~owner_q;
  assign gnt1        = tx_go &  owner_q;
  assign done0       = done_q[0];
  assign done1       = done_q[1];
  assign fifo_rdreq0 = fifo_rdreq & active & ~owner_q;
  assign fifo_rdreq1 = fifo_rdreq & active &  owner_q;
  assign fifo_rddata = active ? (owner_q ? fifo_rddata1 : fifo_rddata0) : 8'h00;
  assign pyd_length  = len_q;
  assign des_mac     = dmac_q;
  assign type_length = type_q;

endmodule
